slip_alu_multislice: RTL and testbench

//  Parametrised, multi-cycle successor of the Slipstream 16-bit LSA2001/181-style ALU.

---
 rtl/slip_alu_pkg.sv | 46 ++++
 rtl/alu181_slice.sv | 58 +++++
 rtl/slip_alu_multislice.sv | 123 ++++++++++++
 tb/tb_slip_alu_multislice.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slip_alu_pkg.sv
// Shared types, select codes and per-bit P/Q operand selection for the
// Slipstream 181-style ALU family.
package slip_alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } alu_state_t;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t OP_ZERO = 4'd3;
   localparam alu_op_t OP_SUB  = 4'd6;
   localparam alu_op_t OP_XOR  = 4'd6;
   localparam alu_op_t OP_ADD  = 4'd9;
   localparam alu_op_t OP_ONE  = 4'd12;

   // Arithmetic mode adds P + Q + c; returns {p, q} for one bit position.
   function automatic logic [1:0] slip_alu_pq(input alu_op_t s, input logic a, input logic b);
      logic p;
      logic q;
      p = a;
      q = 1'b0;
      case (s)
         4'd0:  begin p = a;        q = 1'b0;     end
         4'd1:  begin p = a | b;    q = 1'b0;     end
         4'd2:  begin p = a | ~b;   q = 1'b0;     end
         4'd3:  begin p = 1'b1;     q = 1'b0;     end
         4'd4:  begin p = a;        q = a & ~b;   end
         4'd5:  begin p = a | b;    q = a & ~b;   end
         4'd6:  begin p = a;        q = ~b;       end
         4'd7:  begin p = a & ~b;   q = 1'b1;     end
         4'd8:  begin p = a;        q = a & b;    end
         4'd9:  begin p = a;        q = b;        end
         4'd10: begin p = a | ~b;   q = a & b;    end
         4'd11: begin p = a & b;    q = 1'b1;     end
         4'd12: begin p = a;        q = a;        end
         4'd13: begin p = a | b;    q = a;        end
         4'd14: begin p = a | ~b;   q = a;        end
         default: begin p = a;      q = 1'b1;     end
      endcase
      return {p, q};
   endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational SLICE-bit 181-style function slice with carry in/out.
module alu181_slice
   import slip_alu_pkg::*;
#(
   parameter int unsigned SLICE = 16
) (
   input  alu_op_t          s,
   input  logic             m,
   input  logic             c,
   input  logic [SLICE-1:0] a_k,
   input  logic [SLICE-1:0] b_k,
   output logic [SLICE-1:0] f_k,
   output logic             c_out
);

   logic [SLICE-1:0] p;
   logic [SLICE-1:0] q;
   logic [SLICE-1:0] lf;
   logic [SLICE:0]   sum;

   always_comb begin
      p = '0;
      q = '0;
      for (int unsigned i = 0; i < SLICE; i++) begin
         {p[i], q[i]} = slip_alu_pq(s, a_k[i], b_k[i]);
      end
      sum = {1'b0, p} + {1'b0, q} + (SLICE + 1)'(c);
   end

   always_comb begin
      lf = '0;
      case (s)
         4'd0:  lf = ~a_k;
         4'd1:  lf = ~(a_k | b_k);
         4'd2:  lf = ~a_k & b_k;
         4'd3:  lf = '0;
         4'd4:  lf = ~(a_k & b_k);
         4'd5:  lf = ~b_k;
         4'd6:  lf = a_k ^ b_k;
         4'd7:  lf = a_k & ~b_k;
         4'd8:  lf = ~a_k | b_k;
         4'd9:  lf = ~(a_k ^ b_k);
         4'd10: lf = b_k;
         4'd11: lf = a_k & b_k;
         // In logic mode c marks the least-significant slice, the only one carrying the '1'.
         4'd12: lf[0] = c;
         4'd13: lf = a_k | ~b_k;
         4'd14: lf = a_k | b_k;
         default: lf = a_k;
      endcase
   end

   always_comb begin
      f_k   = m ? lf : sum[SLICE-1:0];
      c_out = m ? 1'b0 : sum[SLICE];
   end

endmodule

// File: rtl/slip_alu_multislice.sv
// Multi-cycle WIDTH-bit 181-style ALU: one SLICE-bit chunk per clock, LSB first,
// with valid/ready handshakes on both sides and ZERO / A==B flags.
module slip_alu_multislice
   import slip_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 16
) (
   input  logic             clock,
   input  logic             resetLow,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             ci_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             co_n,
   output logic             aeb,
   output logic             zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   alu_state_t state;
   alu_state_t state_nx;

   logic [NSLICE-1:0][SLICE-1:0] a_r;
   logic [NSLICE-1:0][SLICE-1:0] b_r;
   logic [NSLICE-1:0][SLICE-1:0] z_r;
   logic [NSLICE-1:0][SLICE-1:0] z_nx;

   alu_op_t          s_r;
   logic             m_r;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             aeb_acc;
   logic             accept;
   logic             last;
   logic             slice_c;
   logic             slice_co;
   logic [SLICE-1:0] f_k;

   always_ff @(posedge clock or negedge resetLow) begin
      if (!resetLow) state <= IDLE;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
      accept   = in_valid && in_ready;
      last     = (idx == LAST);
      case (state)
         IDLE: if (accept) state_nx = RUN;
         RUN:  if (last)   state_nx = DONE;
         DONE: if (out_ready) state_nx = accept ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Carry is unused in logic mode, so it is repurposed to flag slice 0 for the constant-one op.
   assign slice_c = m_r ? (idx == '0) : carry;

   alu181_slice #(.SLICE(SLICE)) u_slice (
      .s     (s_r),
      .m     (m_r),
      .c     (slice_c),
      .a_k   (a_r[idx]),
      .b_k   (b_r[idx]),
      .f_k   (f_k),
      .c_out (slice_co)
   );

   always_comb begin
      z_nx      = z_r;
      z_nx[idx] = f_k;
   end

   always_ff @(posedge clock or negedge resetLow) begin
      if (!resetLow) begin
         a_r     <= '0;
         b_r     <= '0;
         z_r     <= '0;
         s_r     <= '0;
         m_r     <= 1'b0;
         idx     <= '0;
         carry   <= 1'b0;
         aeb_acc <= 1'b0;
         co_n    <= 1'b1;
         aeb     <= 1'b0;
         zero    <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= b;
         s_r     <= s;
         m_r     <= m;
         idx     <= '0;
         carry   <= ~ci_n;
         aeb_acc <= 1'b1;
      end else if (state == RUN) begin
         z_r     <= z_nx;
         carry   <= slice_co;
         aeb_acc <= aeb_acc && (a_r[idx] == b_r[idx]);
         idx     <= idx + 1'b1;
         if (last) begin
            idx  <= '0;
            co_n <= m_r | ~slice_co;
            aeb  <= aeb_acc && (a_r[idx] == b_r[idx]);
            zero <= (z_nx == '0);
         end
      end
   end

   assign out_valid = (state == DONE);
   assign z         = z_r;

endmodule

// File: tb/tb_slip_alu_multislice.sv
// Self-checking bench for slip_alu_multislice: directed table, handshake corner
// sequences, and randomized ops against a full-width arithmetic reference model.
module tb_slip_alu_multislice;

   typedef struct {
      logic [31:0] z;
      logic        co_n;
      logic        aeb;
      logic        zero;
   } res_t;

   typedef struct {
      int          d;
      logic [3:0]  s;
      logic        m;
      logic        ci_n;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      logic        co_n;
      logic        aeb;
      logic        zero;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetLow;
   logic        in_valid;
   logic        out_ready;
   logic [3:0]  s;
   logic        m;
   logic        ci_n;
   logic [31:0] a;
   logic [31:0] b;
   int          sel;

   logic [2:0]  iv, ir, ov, con, ae, ze;
   logic [31:0] z0, z2;
   logic [15:0] z1;

   logic        in_ready_sel, out_valid_sel, co_sel, aeb_sel, zero_sel;
   logic [31:0] z_sel;

   int n_vec = 0;
   int n_err = 0;
   int lat_exp [3] = '{2, 1, 4};
   int wid     [3] = '{32, 16, 32};

   always #5 clk = ~clk;

   assign iv[0] = in_valid && (sel == 0);
   assign iv[1] = in_valid && (sel == 1);
   assign iv[2] = in_valid && (sel == 2);

   slip_alu_multislice #(.WIDTH(32), .SLICE(16)) dut0 (
      .clock(clk), .resetLow(resetLow), .in_valid(iv[0]), .in_ready(ir[0]),
      .s(s), .m(m), .ci_n(ci_n), .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
      .z(z0), .co_n(con[0]), .aeb(ae[0]), .zero(ze[0]));

   slip_alu_multislice #(.WIDTH(16), .SLICE(16)) dut1 (
      .clock(clk), .resetLow(resetLow), .in_valid(iv[1]), .in_ready(ir[1]),
      .s(s), .m(m), .ci_n(ci_n), .a(a[15:0]), .b(b[15:0]), .out_valid(ov[1]), .out_ready(out_ready),
      .z(z1), .co_n(con[1]), .aeb(ae[1]), .zero(ze[1]));

   slip_alu_multislice #(.WIDTH(32), .SLICE(8)) dut2 (
      .clock(clk), .resetLow(resetLow), .in_valid(iv[2]), .in_ready(ir[2]),
      .s(s), .m(m), .ci_n(ci_n), .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready),
      .z(z2), .co_n(con[2]), .aeb(ae[2]), .zero(ze[2]));

   always_comb begin
      in_ready_sel  = ir[0];
      out_valid_sel = ov[0];
      co_sel        = con[0];
      aeb_sel       = ae[0];
      zero_sel      = ze[0];
      z_sel         = z0;
      case (sel)
         1: begin
            in_ready_sel = ir[1]; out_valid_sel = ov[1]; co_sel = con[1];
            aeb_sel = ae[1]; zero_sel = ze[1]; z_sel = {16'h0, z1};
         end
         2: begin
            in_ready_sel = ir[2]; out_valid_sel = ov[2]; co_sel = con[2];
            aeb_sel = ae[2]; zero_sel = ze[2]; z_sel = z2;
         end
         default: ;
      endcase
   end

   // Whole-word reference: the function table evaluated once over w bits.
   function automatic res_t ref_model(input logic [3:0] so, input logic mo, input logic cin_n,
                                      input logic [31:0] ao, input logic [31:0] bo, input int w);
      longint unsigned mask, av, bv, na, nb, p, q, sum, f;
      res_t r;
      mask = (64'd1 << w) - 1;
      av = ao & mask; bv = bo & mask;
      na = ~av & mask; nb = ~bv & mask;
      p = 0; q = 0; f = 0;
      r.co_n = 1'b1;
      if (!mo) begin
         case (so)
            4'd0:  begin p = av;       q = 0;        end
            4'd1:  begin p = av | bv;  q = 0;        end
            4'd2:  begin p = av | nb;  q = 0;        end
            4'd3:  begin p = mask;     q = 0;        end
            4'd4:  begin p = av;       q = av & nb;  end
            4'd5:  begin p = av | bv;  q = av & nb;  end
            4'd6:  begin p = av;       q = nb;       end
            4'd7:  begin p = av & nb;  q = mask;     end
            4'd8:  begin p = av;       q = av & bv;  end
            4'd9:  begin p = av;       q = bv;       end
            4'd10: begin p = av | nb;  q = av & bv;  end
            4'd11: begin p = av & bv;  q = mask;     end
            4'd12: begin p = av;       q = av;       end
            4'd13: begin p = av | bv;  q = av;       end
            4'd14: begin p = av | nb;  q = av;       end
            default: begin p = av;     q = mask;     end
         endcase
         sum = p + q + (cin_n ? 64'd0 : 64'd1);
         f = sum & mask;
         r.co_n = ((sum >> w) & 64'd1) == 0;
      end else begin
         case (so)
            4'd0:  f = na;
            4'd1:  f = ~(av | bv) & mask;
            4'd2:  f = na & bv;
            4'd3:  f = 0;
            4'd4:  f = ~(av & bv) & mask;
            4'd5:  f = nb;
            4'd6:  f = av ^ bv;
            4'd7:  f = av & nb;
            4'd8:  f = na | bv;
            4'd9:  f = ~(av ^ bv) & mask;
            4'd10: f = bv;
            4'd11: f = av & bv;
            4'd12: f = 1;
            4'd13: f = av | nb;
            4'd14: f = av | bv;
            default: f = av;
         endcase
      end
      r.z    = f[31:0];
      r.aeb  = (av == bv);
      r.zero = (f == 0);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input int d, input logic [3:0] so, input logic mo, input logic cin_n,
                       input logic [31:0] ao, input logic [31:0] bo, input string tag);
      int guard;
      @(negedge clk);
      sel = d; s = so; m = mo; ci_n = cin_n; a = ao; b = bo; in_valid = 1'b1;
      guard = 0;
      while (!in_ready_sel && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " in_ready"}, in_ready_sel, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; s = 4'($urandom); m = 1'($urandom); ci_n = 1'($urandom);
   endtask

   task automatic wait_result(input int d, input res_t e, input string tag);
      int lat;
      lat = 0;
      while (!out_valid_sel && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, lat, lat_exp[d]);
      check({tag, " z"}, z_sel, e.z);
      check({tag, " co_n"}, co_sel, e.co_n);
      check({tag, " aeb"}, aeb_sel, e.aeb);
      check({tag, " zero"}, zero_sel, e.zero);
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, out_valid_sel, 0);
   endtask

   task automatic run_op(input int d, input logic [3:0] so, input logic mo, input logic cin_n,
                         input logic [31:0] ao, input logic [31:0] bo, input res_t e, input string tag);
      send(d, so, mo, cin_n, ao, bo, tag);
      wait_result(d, e, tag);
      release_result(tag);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [10];
      res_t e;
      res_t ey;

      tbl[0] = '{0, 4'd9,  1'b0, 1'b1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{0, 4'd6,  1'b0, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{0, 4'd6,  1'b0, 1'b0, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{0, 4'd6,  1'b1, 1'b1, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{0, 4'd9,  1'b1, 1'b1, 32'h00001234, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1, 4'd12, 1'b0, 1'b1, 32'h00008000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{0, 4'd3,  1'b0, 1'b0, 32'h0000DEAD, 32'h0000BEEF, 32'h00000000, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{2, 4'd12, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{2, 4'd15, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
      tbl[9] = '{1, 4'd9,  1'b0, 1'b0, 32'h0000FFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};

      resetLow = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 0;
      s = '0; m = 1'b0; ci_n = 1'b1; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         sel = d;
         #1;
         check($sformatf("reset d%0d out_valid", d), out_valid_sel, 0);
         check($sformatf("reset d%0d z", d), z_sel, 0);
         check($sformatf("reset d%0d co_n", d), co_sel, 1);
         check($sformatf("reset d%0d aeb", d), aeb_sel, 0);
         check($sformatf("reset d%0d zero", d), zero_sel, 0);
         check($sformatf("reset d%0d in_ready", d), in_ready_sel, 1);
      end
      @(negedge clk);
      resetLow = 1'b1;

      for (int i = 0; i < 10; i++) begin
         e.z = tbl[i].z; e.co_n = tbl[i].co_n; e.aeb = tbl[i].aeb; e.zero = tbl[i].zero;
         run_op(tbl[i].d, tbl[i].s, tbl[i].m, tbl[i].ci_n, tbl[i].a, tbl[i].b, e,
                $sformatf("tbl%0d", i));
      end

      // Backpressure, then a same-cycle release-and-accept.
      e  = ref_model(4'd9, 1'b0, 1'b1, 32'h12345678, 32'h0F0F0F0F, 32);
      ey = ref_model(4'd6, 1'b0, 1'b0, 32'h00000100, 32'h00000001, 32);
      send(0, 4'd9, 1'b0, 1'b1, 32'h12345678, 32'h0F0F0F0F, "bp");
      wait_result(0, e, "bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp hold%0d z", i), z_sel, e.z);
         check($sformatf("bp hold%0d co_n", i), co_sel, e.co_n);
         check($sformatf("bp hold%0d out_valid", i), out_valid_sel, 1);
         check($sformatf("bp hold%0d in_ready", i), in_ready_sel, 0);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      s = 4'd6; m = 1'b0; ci_n = 1'b0; a = 32'h00000100; b = 32'h00000001;
      #1;
      check("bp b2b in_ready", in_ready_sel, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0; a = $urandom; b = $urandom;
      check("bp b2b out_valid low", out_valid_sel, 0);
      wait_result(0, ey, "bp b2b");
      release_result("bp b2b");

      // Reset asserted while an op is mid-RUN.
      send(2, 4'd9, 1'b0, 1'b1, 32'h11111111, 32'h22222222, "rst");
      @(posedge clk);
      #1;
      check("rst pre z slice0", z_sel[7:0], 8'h33);
      @(negedge clk);
      resetLow = 1'b0;
      #1;
      check("rst out_valid", out_valid_sel, 0);
      check("rst z", z_sel, 0);
      @(negedge clk);
      resetLow = 1'b1;
      @(posedge clk);
      #1;
      check("rst in_ready", in_ready_sel, 1);
      check("rst stays idle", out_valid_sel, 0);
      e = ref_model(4'd6, 1'b0, 1'b0, 32'h00000010, 32'h00000003, 32);
      run_op(2, 4'd6, 1'b0, 1'b0, 32'h00000010, 32'h00000003, e, "rst new");

      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 40; i++) begin
            logic [3:0]  rs;
            logic        rm, rc;
            logic [31:0] ra, rb;
            rs = 4'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 7) == 0) ra = '0;
            e = ref_model(rs, rm, rc, ra, rb, wid[d]);
            run_op(d, rs, rm, rc, ra, rb, e, $sformatf("rnd d%0d #%0d s%0d m%0d", d, i, rs, rm));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
